// File: rtl/regfile_param_if.sv
// Register file access bundle: one write port, two read ports and write-activity status.
// The decode stage drives through master; the register file receives through slave.
interface regfile_param_if #(
   parameter int WIDTH     = 64,
   parameter int ADDR_BITS = 5
);
   localparam int NREGS = 1 << ADDR_BITS;

   logic                 RegWrite;
   logic [ADDR_BITS-1:0] WriteRegister;
   logic [WIDTH-1:0]     WriteData;
   logic [ADDR_BITS-1:0] ReadRegister1;
   logic [ADDR_BITS-1:0] ReadRegister2;
   logic [WIDTH-1:0]     ReadData1;
   logic [WIDTH-1:0]     ReadData2;
   logic [NREGS-1:0]     wr_onehot;
   logic [15:0]          wr_count;

   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2, wr_onehot, wr_count
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2, wr_onehot, wr_count
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one-hot write decode, one sync write port, two comb read ports,
// optional hardwired-zero top register and optional write-to-read bypass.
module regfile_param_cell #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (we) q <= d;
   end
endmodule

module regfile_param #(
   parameter int WIDTH     = 64,
   parameter int ADDR_BITS = 5,
   parameter bit HAS_ZERO  = 1'b1,
   parameter bit BYPASS    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   regfile_param_if.slave   rf
);
   localparam int NREGS = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] ZREG = ADDR_BITS'(NREGS - 1);

   logic [NREGS-1:0]            dec;
   logic [NREGS-1:0]            en;
   logic [NREGS-1:0][WIDTH-1:0] regs;
   logic [NREGS-1:0]            onehot_q;
   logic [15:0]                 count_q;

   always_comb begin
      dec = '0;
      for (int i = 0; i < NREGS; i++)
         dec[i] = rf.RegWrite && (rf.WriteRegister == ADDR_BITS'(i));
   end

   // The zero register never takes a write, so it never counts as one either.
   always_comb begin
      en = dec;
      if (HAS_ZERO) en[NREGS-1] = 1'b0;
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_reg
      regfile_param_cell #(.WIDTH(WIDTH)) u_cell (
         .clk   (clk),
         .reset (reset),
         .we    (en[g]),
         .d     (rf.WriteData),
         .q     (regs[g])
      );
   end

   // Zero-register check outranks bypass so a write to it can never leak through.
   function automatic logic [WIDTH-1:0] rd_mux(
      input logic [ADDR_BITS-1:0]        r,
      input logic                        we,
      input logic [ADDR_BITS-1:0]        wa,
      input logic [WIDTH-1:0]            wd,
      input logic [NREGS-1:0][WIDTH-1:0] st
   );
      logic [WIDTH-1:0] v;
      v = st[r];
      if (BYPASS && we && (wa == r)) v = wd;
      if (HAS_ZERO && (r == ZREG))   v = '0;
      return v;
   endfunction

   always_comb rf.ReadData1 = rd_mux(rf.ReadRegister1, rf.RegWrite, rf.WriteRegister, rf.WriteData, regs);
   always_comb rf.ReadData2 = rd_mux(rf.ReadRegister2, rf.RegWrite, rf.WriteRegister, rf.WriteData, regs);

   always_ff @(posedge clk) begin
      if (reset) begin
         onehot_q <= '0;
         count_q  <= '0;
      end else begin
         onehot_q <= en;
         if ((|en) && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      end
   end

   assign rf.wr_onehot = onehot_q;
   assign rf.wr_count  = count_q;
endmodule
